// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, branch/jump flush
// bubbles and saturating stall/flush counters for performance debug.
module if_id_stage #(
    parameter logic [31:0] NOP   = 32'h0000_0013,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instruction_if,
    input  logic [31:0]      PC,
    input  logic             IF_flush,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rd,
    output logic [31:0]      Instruction_id,
    output logic [31:0]      PC_id,
    output logic             Valid_id,
    output logic             IFWrite,
    output logic             Stall,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_q, pc_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2;
    logic       rs1_used, rs2_used;
    logic       stall;

    assign opcode = instr_q[6:0];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];

    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        unique case (opcode)
            OP_IMM, OP_LOAD, OP_JALR:     rs1_used = 1'b1;
            OP_REG, OP_STORE, OP_BRANCH: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            default: ;
        endcase
    end

    // Only registered state and ID/EX inputs feed the hazard, keeping fetch off this path.
    assign stall = valid_q && ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                   ((rs1_used && (rs1 == ID_EX_rd)) || (rs2_used && (rs2 == ID_EX_rd)));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        instr_d     = instr_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall) begin
            if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
        end else if (IF_flush) begin
            instr_d = NOP;
            pc_d    = PC;
            valid_d = 1'b0;
            if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
        end else begin
            instr_d = Instruction_if;
            pc_d    = PC;
            valid_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q     <= NOP;
            pc_q        <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Instruction_id = instr_q;
    assign PC_id          = pc_q;
    assign Valid_id       = valid_q;
    assign Stall          = stall;
    assign IFWrite        = ~stall;
    assign StallCount     = stall_cnt_q;
    assign FlushCount     = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed steps followed by random
// traffic, all compared against a rule-level reference model.
module tb_if_id_stage;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          CNT_W = 2;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      Instruction_if;
    logic [31:0]      PC;
    logic             IF_flush;
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_rd;
    logic [31:0]      Instruction_id;
    logic [31:0]      PC_id;
    logic             Valid_id;
    logic             IFWrite;
    logic             Stall;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    if_id_stage #(.NOP(NOP), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .Instruction_if(Instruction_if),
        .PC            (PC),
        .IF_flush      (IF_flush),
        .ID_EX_MemRead (ID_EX_MemRead),
        .ID_EX_rd      (ID_EX_rd),
        .Instruction_id(Instruction_id),
        .PC_id         (PC_id),
        .Valid_id      (Valid_id),
        .IFWrite       (IFWrite),
        .Stall         (Stall),
        .StallCount    (StallCount),
        .FlushCount    (FlushCount)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state: what decode should be holding right now.
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_valid;
    int          m_sc;
    int          m_fc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {7'b0010011, 7'b0000011, 7'b1100111,
                          7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic bit model_stall();
        bit hit;
        int rd;
        rd  = int'(ID_EX_rd);
        hit = (reads_rs1(m_instr[6:0]) && int'(m_instr[19:15]) == rd) ||
              (reads_rs2(m_instr[6:0]) && int'(m_instr[24:20]) == rd);
        return m_valid && ID_EX_MemRead && rd != 0 && hit;
    endfunction

    task automatic model_reset();
        m_instr = NOP;
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_sc    = 0;
        m_fc    = 0;
    endtask

    task automatic check_all(input string ctx);
        bit s;
        s = model_stall();
        check({ctx, ".instr"},  Instruction_id,     m_instr);
        check({ctx, ".pc"},     PC_id,              m_pc);
        check({ctx, ".valid"},  32'(Valid_id),      32'(m_valid));
        check({ctx, ".scnt"},   32'(StallCount),    32'(m_sc));
        check({ctx, ".fcnt"},   32'(FlushCount),    32'(m_fc));
        check({ctx, ".stall"},  32'(Stall),         32'(s));
        check({ctx, ".ifwr"},   32'(IFWrite),       32'(!s));
    endtask

    // Drive one cycle of inputs, check pre-edge state, clock, advance the model.
    task automatic step(input string ctx, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic mr, input logic [4:0] rd);
        bit s;
        Instruction_if = ins;
        PC             = pc;
        IF_flush       = fl;
        ID_EX_MemRead  = mr;
        ID_EX_rd       = rd;
        #1;
        check_all(ctx);
        s = model_stall();
        @(posedge clk);
        if (s) begin
            if (m_sc < CMAX) m_sc++;
        end else if (fl) begin
            m_instr = NOP;
            m_pc    = pc;
            m_valid = 1'b0;
            if (m_fc < CMAX) m_fc++;
        end else begin
            m_instr = ins;
            m_pc    = pc;
            m_valid = 1'b1;
        end
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [9];
        logic [6:0] op;
        ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0110011, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
        op  = ops[$urandom_range(0, 8)];
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom), op};
    endfunction

    initial begin
        // Reset held for three cycles with a live instruction at the input.
        reset          = 1'b0;
        Instruction_if = 32'h00A0_0093;
        PC             = 32'h0;
        IF_flush       = 1'b0;
        ID_EX_MemRead  = 1'b0;
        ID_EX_rd       = 5'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset.instr", Instruction_id, 32'h0000_0013);
        check("reset.pc", PC_id, 32'h0);
        check("reset.valid", 32'(Valid_id), 32'h0);
        check("reset.ifwrite", 32'(IFWrite), 32'h1);
        check("reset.counts", 32'({StallCount, FlushCount}), 32'h0);
        reset = 1'b1;
        step("rel", 32'h00A0_0093, 32'h0, 1'b0, 1'b0, 5'd0);
        check("rel.instr", Instruction_id, 32'h00A0_0093);
        check("rel.valid", 32'(Valid_id), 32'h1);

        // Straight-line fetch.
        step("sl0", 32'h0010_0113, 32'h0, 1'b0, 1'b0, 5'd0);
        step("sl4", 32'h0020_0193, 32'h4, 1'b0, 1'b0, 5'd0);
        check("sl.pc0", PC_id, 32'h4);
        step("sl8", 32'h0030_0213, 32'h8, 1'b0, 1'b0, 5'd0);
        check("sl.pc8", PC_id, 32'h8);
        check("sl.scnt", 32'(StallCount), 32'h0);

        // Load-use on rs2 of add x3,x1,x2.
        step("lu.load", 32'h0020_81B3, 32'hC, 1'b0, 1'b0, 5'd0);
        ID_EX_MemRead = 1'b1;
        ID_EX_rd      = 5'd2;
        #1;
        check("lu.stall", 32'(Stall), 32'h1);
        check("lu.ifwrite", 32'(IFWrite), 32'h0);
        step("lu.hold", 32'h0040_0293, 32'h10, 1'b0, 1'b1, 5'd2);
        check("lu.held", Instruction_id, 32'h0020_81B3);
        check("lu.heldpc", PC_id, 32'hC);
        step("lu.adv", 32'h0040_0293, 32'h10, 1'b0, 1'b0, 5'd2);
        check("lu.advpc", PC_id, 32'h10);
        check("lu.scnt", 32'(StallCount), 32'h1);

        // No false hazard: rd = x0, and lui which reads no register.
        step("nf.add", 32'h0020_81B3, 32'h14, 1'b0, 1'b0, 5'd0);
        ID_EX_MemRead = 1'b1;
        ID_EX_rd      = 5'd0;
        #1;
        check("nf.rd0", 32'(Stall), 32'h0);
        step("nf.lui", 32'h0000_20B7, 32'h18, 1'b0, 1'b1, 5'd0);
        ID_EX_rd = 5'd2;
        #1;
        check("nf.lui", 32'(Stall), 32'h0);

        // Flush, then a NOP bubble that must not stall on x0 / x0-matching rd.
        step("fl", 32'h0020_81B3, 32'h10, 1'b1, 1'b1, 5'd2);
        check("fl.instr", Instruction_id, NOP);
        check("fl.pc", PC_id, 32'h10);
        check("fl.valid", 32'(Valid_id), 32'h0);
        check("fl.fcnt", 32'(FlushCount), 32'h1);

        // Flush together with a stall: register holds, flush not counted.
        step("fs.load", 32'h0020_81B3, 32'h20, 1'b0, 1'b0, 5'd0);
        step("fs.both", 32'h0000_0013, 32'h24, 1'b1, 1'b1, 5'd1);
        check("fs.instr", Instruction_id, 32'h0020_81B3);
        check("fs.fcnt", 32'(FlushCount), 32'h1);

        // Stall counter saturation at 3 after five more stall cycles.
        for (int i = 0; i < 5; i++) step("sat", 32'h0000_0013, 32'h24, 1'b0, 1'b1, 5'd1);
        check("sat.scnt", 32'(StallCount), 32'h3);

        // Asynchronous reset between clock edges, mid-stall.
        #2;
        reset = 1'b0;
        #1;
        check("ar.scnt", 32'(StallCount), 32'h0);
        check("ar.fcnt", 32'(FlushCount), 32'h0);
        check("ar.instr", Instruction_id, NOP);
        check("ar.stall", 32'(Stall), 32'h0);
        model_reset();
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_instr = Instruction_if;
        m_pc    = PC;
        m_valid = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step("rnd", rand_instr(), 32'($urandom) & 32'hFFFF_FFFC,
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline register with integrated load-use hazard detection for the 5-stage RISC-V CPU. It sits directly downstream of the instruction-fetch stage and captures the fetched instruction and its PC each cycle. It inserts a NOP bubble on a taken branch or jump, and holds both itself and the fetch PC on a load-use hazard; the PC hold is driven through `IFWrite`. It also keeps saturating stall and flush counters for performance debug.

## Interface

**Parameters**
- `NOP`, default 32'h00000013, the instruction word presented to ID on reset and on flush (`addi x0,x0,0`).
- `CNT_W`, default 16, width of the stall and flush counters.

**Ports**
- `clk`, input, 1, single clock; all state changes on the rising edge.
- `reset`, input, 1, asynchronous, active-low; clears all state while low.
- `Instruction_if`, input, 32, instruction word from fetch.
- `PC`, input, 32, PC of `Instruction_if`.
- `IF_flush`, input, 1, taken branch or jump; squash the instruction being fetched.
- `ID_EX_MemRead`, input, 1, the instruction in EX is a load.
- `ID_EX_rd`, input, 5, destination register of the instruction in EX.
- `Instruction_id`, output, 32, registered instruction for decode.
- `PC_id`, output, 32, registered PC for decode.
- `Valid_id`, output, 1, `Instruction_id` is a real instruction and not a bubble.
- `IFWrite`, output, 1, PC write enable to fetch; 0 during a stall.
- `Stall`, output, 1, load-use hazard; ID/EX must zero its control fields this cycle.
- `StallCount`, output, CNT_W, number of stall cycles, saturating.
- `FlushCount`, output, CNT_W, number of flush cycles, saturating.

## Operation

**Field decode.** These are decoded combinationally from the registered `Instruction_id`:
- opcode = [6:0], rs1 = [19:15], rs2 = [24:20].

**Register usage.**
- rs1 is used for opcodes 0010011, 0000011, 1100111, 0110011, 0100011 and 1100011.
- rs2 is used for opcodes 0110011, 0100011 and 1100011.
- All other opcodes use neither register (for example 0110111, 0010111, 1101111).

**Hazard condition.**
- `Stall` = `Valid_id` & `ID_EX_MemRead` & (`ID_EX_rd` != 0) & ((rs1 used & rs1 == `ID_EX_rd`) | (rs2 used & rs2 == `ID_EX_rd`)).
- `IFWrite` = ~`Stall`.

**Register update**, evaluated at each clock edge in this priority order:
1. `Stall` = 1: hold `Instruction_id`, `PC_id` and `Valid_id`. `IF_flush` is ignored; the branch re-resolves after the stall clears, and fetch also holds because `IFWrite` = 0.
2. `IF_flush` = 1: `Instruction_id` ← `NOP`, `PC_id` ← `PC`, `Valid_id` ← 0.
3. Otherwise: `Instruction_id` ← `Instruction_if`, `PC_id` ← `PC`, `Valid_id` ← 1.

**Counters.**
- `StallCount` increments on every edge where `Stall` = 1.
- `FlushCount` increments on every edge where `IF_flush` = 1 and `Stall` = 0.
- Both saturate at 2^CNT_W−1 and never wrap.

**Reset** (asynchronous, while `reset` = 0):
- `Instruction_id` = `NOP`, `PC_id` = 0, `Valid_id` = 0.
- `StallCount` = 0, `FlushCount` = 0.
- `Stall` = 0 and `IFWrite` = 1, because `Valid_id` = 0.

## Timing

**Latency and combinational paths.**
- Fetch to decode latency is 1 cycle.
- `Stall` and `IFWrite` are purely combinational from registered state plus the `ID_EX_*` inputs, valid in the same cycle.
- No combinational path exists from `Instruction_if`, `PC` or `IF_flush` to `Stall` or `IFWrite`.

**Load-use stall sequence.**
- A load in EX with a dependent instruction in ID produces exactly one stall cycle.
- On the next edge ID/EX holds a bubble, so `ID_EX_MemRead` drops and `Stall` deasserts.

**Edge cases.**
- Back-to-back loads with a chain of dependences each stall 1 cycle independently.
- Reset asserted mid-stall or mid-flush takes effect immediately and asynchronously.
- Reset release is synchronised externally; the first capture occurs on the first rising edge with `reset` = 1.
- `Valid_id` = 0 suppresses stalls, so a flushed NOP never stalls even though its rs1 field matches x0.

## Test plan

1. **Reset:** hold `reset`=0 for 3 cycles with `Instruction_if`=32'h00A00093 → `Instruction_id`=32'h00000013, `PC_id`=0, `Valid_id`=0, `IFWrite`=1 and both counters 0. Release reset; after 1 edge `Instruction_id`=32'h00A00093 and `Valid_id`=1.
2. **Straight-line:** feed PCs 0,4,8 → `PC_id` follows one cycle later with no stalls, and `StallCount`=0.
3. **Load-use:** set `Instruction_id`=32'h002081B3 (add x3,x1,x2) with `ID_EX_MemRead`=1 and `ID_EX_rd`=2 → `Stall`=1 and `IFWrite`=0, and the outputs hold for one edge. Then drop MemRead → the register advances and `StallCount`=1.
4. **No false hazard:** set `ID_EX_rd`=0 with MemRead=1, or use lui 32'h000020B7 with rd=2 in EX → `Stall`=0.
5. **Flush:** assert `IF_flush`=1 with `PC`=32'h10 → next cycle `Instruction_id`=NOP, `PC_id`=32'h10, `Valid_id`=0 and `FlushCount`=1. Assert `IF_flush` together with `Stall` → the register holds and `FlushCount` is unchanged.
6. **Saturation and async reset:** with CNT_W=2, force 5 stall cycles → `StallCount`=3. Drop `reset` between clock edges → all counters 0 immediately.
